alu_instr_sequencer: RTL and testbench

Moore-style control unit for the Phase 1 bus datapath. It runs the fetch steps T0–T2 and the execute steps for register-register ALU instructions. It drives every datapath in/out/ALU-select strobe from its state register. It replaces the hand-written per-instruction state machines in the testbenches and lets instructions run back to back.

---
 rtl/alu_instr_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// Moore control unit for the bus datapath: fetch steps T0-T2 plus register-register ALU execute steps.
// Optional build macro SEQ_STEP_EN adds a "step" input that gates every state transition.

module alu_instr_sequencer #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_rdy,
`ifdef SEQ_STEP_EN
    input  logic        step,
`endif
    input  logic [31:0] ir,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic [12:0] alu_sel,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        ERR  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        CLS_TRI,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_BAD
    } op_class_t;

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

    state_t     state, state_n, after_done;
    logic [7:0] wait_cnt, wait_cnt_n;
    logic [1:0] code_q, code_n;
    logic       advance;

    logic [4:0]  opcode;
    logic [15:0] sel_ra, sel_rb, sel_rc;
    op_class_t   op_class;
    logic [12:0] op_sel;

`ifdef SEQ_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    assign opcode = ir[31:27];
    assign sel_ra = 16'd1 << ir[26:23];
    assign sel_rb = 16'd1 << ir[22:19];
    assign sel_rc = 16'd1 << ir[18:15];

    logic unused_ir_low;
    assign unused_ir_low = ^ir[14:0];

    // NOTE: every variable written in an always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        op_class = CLS_BAD;
        op_sel   = '0;
        case (opcode)
            5'b00011: begin op_class = CLS_TRI;    op_sel = 13'd1 << 0;  end
            5'b00100: begin op_class = CLS_TRI;    op_sel = 13'd1 << 1;  end
            5'b00101: begin op_class = CLS_TRI;    op_sel = 13'd1 << 2;  end
            5'b00110: begin op_class = CLS_TRI;    op_sel = 13'd1 << 3;  end
            5'b00111: begin op_class = CLS_TRI;    op_sel = 13'd1 << 7;  end
            5'b01000: begin op_class = CLS_TRI;    op_sel = 13'd1 << 8;  end
            5'b01001: begin op_class = CLS_TRI;    op_sel = 13'd1 << 4;  end
            5'b01010: begin op_class = CLS_TRI;    op_sel = 13'd1 << 5;  end
            5'b01011: begin op_class = CLS_TRI;    op_sel = 13'd1 << 6;  end
            5'b01111: begin op_class = CLS_MULDIV; op_sel = 13'd1 << 11; end
            5'b10000: begin op_class = CLS_MULDIV; op_sel = 13'd1 << 12; end
            5'b10001: begin op_class = CLS_UNARY;  op_sel = 13'd1 << 9;  end
            5'b10010: begin op_class = CLS_UNARY;  op_sel = 13'd1 << 10; end
            default:  begin op_class = CLS_BAD;    op_sel = '0;          end
        endcase
    end

    assign after_done = run ? T0 : IDLE;

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        code_n     = code_q;
        if (advance) begin
            case (state)
                IDLE: if (run) state_n = T0;
                T0:   state_n = T1;
                T1: begin
                    // A ready on the limit cycle still wins over the timeout.
                    if (mem_rdy) begin
                        state_n    = T2;
                        wait_cnt_n = '0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state_n    = ERR;
                        wait_cnt_n = '0;
                        code_n     = 2'b10;
                    end else begin
                        wait_cnt_n = wait_cnt + 8'd1;
                    end
                end
                T2:   state_n = T3;
                T3: begin
                    if (op_class == CLS_BAD) begin
                        state_n = ERR;
                        code_n  = 2'b01;
                    end else begin
                        state_n = T4;
                    end
                end
                T4:      state_n = (op_class == CLS_UNARY)  ? after_done : T5;
                T5:      state_n = (op_class == CLS_MULDIV) ? T6 : after_done;
                T6:      state_n = after_done;
                ERR:     state_n = ERR;
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state    <= IDLE;
            wait_cnt <= '0;
            code_q   <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            code_q   <= code_n;
        end
    end

    always_comb begin
        Rin      = '0;
        Rout     = '0;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        alu_sel  = '0;
        done     = 1'b0;
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                case (op_class)
                    CLS_TRI:    begin Rout = sel_rb; Yin = 1'b1; end
                    CLS_MULDIV: begin Rout = sel_ra; Yin = 1'b1; end
                    CLS_UNARY:  begin Rout = sel_rb; alu_sel = op_sel; Zin = 1'b1; end
                    default:    ;
                endcase
            end
            T4: begin
                case (op_class)
                    CLS_TRI:    begin Rout = sel_rc; alu_sel = op_sel; Zin = 1'b1; end
                    CLS_MULDIV: begin Rout = sel_rb; alu_sel = op_sel; Zin = 1'b1; end
                    CLS_UNARY:  begin Zlowout = 1'b1; Rin = sel_ra; done = 1'b1; end
                    default:    ;
                endcase
            end
            T5: begin
                if (op_class == CLS_MULDIV) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end else begin
                    Zlowout = 1'b1;
                    Rin     = sel_ra;
                    done    = 1'b1;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign err       = (state == ERR);
    assign err_code  = code_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: a trace model expands each instruction into its
// expected per-cycle outputs, which are compared against the DUT one cycle at a time.

module tb_alu_instr_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic        mem_rdy = 1'b0;
    logic [31:0] ir = '0;
    logic [15:0] Rin, Rout;
    logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
    logic        MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [12:0] alu_sel;
    logic        done, err;
    logic [1:0]  err_code;
    logic [3:0]  state_dbg;

    alu_instr_sequencer #(.WAIT_LIMIT(15)) dut (
        .clock(clock), .clear(clear), .run(run), .mem_rdy(mem_rdy),
`ifdef SEQ_STEP_EN
        .step(1'b1),
`endif
        .ir(ir), .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .alu_sel(alu_sel), .done(done),
        .err(err), .err_code(err_code), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // Strobe bit positions in the 14-bit strobe group of the observation vector.
    localparam int B_PCOUT = 13, B_MARIN = 12, B_INCPC = 11, B_ZIN = 10, B_ZLOW = 9, B_ZHIGH = 8;
    localparam int B_PCIN = 7, B_READ = 6, B_MDRIN = 5, B_MDROUT = 4, B_IRIN = 3, B_YIN = 2;
    localparam int B_HIIN = 1, B_LOIN = 0;

    typedef struct {
        string       lab;
        logic        clr;
        logic        runv;
        logic        rdy;
        logic        set_ir;
        logic [31:0] irv;
        logic [66:0] exp;
    } step_t;

    step_t      plan_q[$];
    int         total = 0;
    int         bad = 0;
    logic       next_clr = 1'b1;
    logic [1:0] cur_code = 2'b00;
    int         abort_at = -1;
    bit         aborted = 1'b0;

    logic [4:0] legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                   5'd15, 5'd16, 5'd17, 5'd18};

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] n);
        return 16'd1 << n;
    endfunction

    function automatic logic [13:0] sb(input int b);
        return 14'd1 << b;
    endfunction

    // kind: 0 three-operand, 1 MUL/DIV, 2 NEG/NOT, 3 illegal
    function automatic void op_info(input logic [4:0] opc, output int kind, output int abit);
        case (opc)
            5'd3:    begin kind = 0; abit = 0;  end
            5'd4:    begin kind = 0; abit = 1;  end
            5'd5:    begin kind = 0; abit = 2;  end
            5'd6:    begin kind = 0; abit = 3;  end
            5'd7:    begin kind = 0; abit = 7;  end
            5'd8:    begin kind = 0; abit = 8;  end
            5'd9:    begin kind = 0; abit = 4;  end
            5'd10:   begin kind = 0; abit = 5;  end
            5'd11:   begin kind = 0; abit = 6;  end
            5'd15:   begin kind = 1; abit = 11; end
            5'd16:   begin kind = 1; abit = 12; end
            5'd17:   begin kind = 2; abit = 9;  end
            5'd18:   begin kind = 2; abit = 10; end
            default: begin kind = 3; abit = 0;  end
        endcase
    endfunction

    function automatic void push(input string lab, input logic [3:0] st, input logic [15:0] rin,
                                 input logic [15:0] rout, input logic [13:0] strb, input logic [12:0] alu,
                                 input logic dn, input logic runv, input logic rdy,
                                 input logic set_ir, input logic [31:0] irv);
        step_t s;
        if (aborted) return;
        s.lab    = lab;
        s.clr    = next_clr;
        s.runv   = runv;
        s.rdy    = rdy;
        s.set_ir = set_ir;
        s.irv    = irv;
        s.exp    = {rin, rout, strb, alu, dn, (st == 4'd8), (st == 4'd8) ? cur_code : 2'b00, st};
        next_clr = 1'b1;
        if (int'(st) == abort_at) begin
            s.clr   = 1'b0;
            s.runv  = 1'b0;
            aborted = 1'b1;
        end
        plan_q.push_back(s);
    endfunction

    function automatic void push_err_tail(input logic [1:0] code);
        cur_code = code;
        for (int i = 0; i < 3; i++)
            push("ERR", 4'd8, '0, '0, '0, '0, 1'b0, rbit(), rbit(), 1'b0, '0);
        next_clr = 1'b0;
        push("ERR_CLR", 4'd8, '0, '0, '0, '0, 1'b0, 1'b1, rbit(), 1'b0, '0);
        cur_code = 2'b00;
        push("POST_CLR", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endfunction

    function automatic void push_fetch(input logic [31:0] instr, input int waits, input bit from_idle);
        if (from_idle)
            push("IDLE", 4'd0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        push("T0", 4'd1, '0, '0, sb(B_PCOUT) | sb(B_MARIN) | sb(B_INCPC) | sb(B_ZIN), '0, 1'b0,
             rbit(), rbit(), 1'b0, '0);
        for (int w = 0; w <= waits; w++)
            push("T1", 4'd2, '0, '0, sb(B_ZLOW) | sb(B_PCIN) | sb(B_READ) | sb(B_MDRIN), '0, 1'b0,
                 rbit(), (w == waits), 1'b0, '0);
        push("T2", 4'd3, '0, '0, sb(B_MDROUT) | sb(B_IRIN), '0, 1'b0, rbit(), rbit(), 1'b1, instr);
    endfunction

    // Expand one instruction into its expected cycle trace; cont is the run level on the final step.
    function automatic void gen_instr(input logic [31:0] instr, input int waits, input bit from_idle,
                                      input bit cont);
        logic [3:0]  ra, rb, rc;
        logic [12:0] alu;
        int          kind, abit;
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        op_info(instr[31:27], kind, abit);
        alu = 13'd1 << abit;
        push_fetch(instr, waits, from_idle);
        case (kind)
            0: begin
                push("T3", 4'd4, '0, oh(rb), sb(B_YIN), '0, 1'b0, rbit(), rbit(), 1'b0, '0);
                push("T4", 4'd5, '0, oh(rc), sb(B_ZIN), alu, 1'b0, rbit(), rbit(), 1'b0, '0);
                push("T5", 4'd6, oh(ra), '0, sb(B_ZLOW), '0, 1'b1, cont, rbit(), 1'b0, '0);
            end
            1: begin
                push("T3", 4'd4, '0, oh(ra), sb(B_YIN), '0, 1'b0, rbit(), rbit(), 1'b0, '0);
                push("T4", 4'd5, '0, oh(rb), sb(B_ZIN), alu, 1'b0, rbit(), rbit(), 1'b0, '0);
                push("T5", 4'd6, '0, '0, sb(B_ZLOW) | sb(B_LOIN), '0, 1'b0, rbit(), rbit(), 1'b0, '0);
                push("T6", 4'd7, '0, '0, sb(B_ZHIGH) | sb(B_HIIN), '0, 1'b1, cont, rbit(), 1'b0, '0);
            end
            2: begin
                push("T3", 4'd4, '0, oh(rb), sb(B_ZIN), alu, 1'b0, rbit(), rbit(), 1'b0, '0);
                push("T4", 4'd5, oh(ra), '0, sb(B_ZLOW), '0, 1'b1, cont, rbit(), 1'b0, '0);
            end
            default: begin
                push("T3_ILL", 4'd4, '0, '0, '0, '0, 1'b0, rbit(), rbit(), 1'b0, '0);
                push_err_tail(2'b01);
            end
        endcase
    endfunction

    function automatic logic [31:0] make_instr(input logic [4:0] opc);
        return {opc, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
    endfunction

    function automatic logic [31:0] rand_legal();
        return make_instr(legal_ops[$urandom_range(0, 12)]);
    endfunction

    task automatic execute();
        step_t       s;
        logic [66:0] obs;
        while (plan_q.size() > 0) begin
            s = plan_q.pop_front();
            @(negedge clock);
            clear   = s.clr;
            run     = s.runv;
            mem_rdy = s.rdy;
            if (s.set_ir) ir = s.irv;
            #1;
            obs = {Rin, Rout, PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin,
                   MDRout, IRin, Yin, HIin, LOin, alu_sel, done, err, err_code, state_dbg};
            total++;
            if (obs !== s.exp) begin
                bad++;
                $display("FAIL %s @%0t: got %h want %h", s.lab, $time, obs, s.exp);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            next_clr = 1'b0;
            push("RESET", 4'd0, '0, '0, '0, '0, 1'b0, rbit(), rbit(), 1'b0, '0);
        end
        push("IDLE_HOLD", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0, rbit(), 1'b0, '0);
        push("IDLE_HOLD", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0, rbit(), 1'b0, '0);
        execute();
    endtask

    task automatic test_shra();
        gen_instr(32'h5382_0000, 0, 1'b1, 1'b0);
        execute();
    endtask

    task automatic test_back_to_back();
        logic [31:0] mul_r2_r3;
        mul_r2_r3 = {5'b01111, 4'd2, 4'd3, 4'd0, 15'd0};
        gen_instr(mul_r2_r3, 0, 1'b1, 1'b1);
        gen_instr(mul_r2_r3, 0, 1'b0, 1'b1);
        gen_instr(make_instr(5'd17), 1, 1'b0, 1'b0);
        execute();
    endtask

    task automatic test_mem_wait();
        gen_instr(make_instr(5'd3), 3, 1'b1, 1'b0);
        execute();
    endtask

    task automatic test_wait_limit_edge();
        gen_instr(make_instr(5'd16), 14, 1'b1, 1'b0);
        execute();
    endtask

    task automatic test_timeout();
        push("IDLE", 4'd0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        push("T0", 4'd1, '0, '0, sb(B_PCOUT) | sb(B_MARIN) | sb(B_INCPC) | sb(B_ZIN), '0, 1'b0,
             1'b1, 1'b0, 1'b0, '0);
        for (int w = 0; w < 15; w++)
            push("T1_WAIT", 4'd2, '0, '0, sb(B_ZLOW) | sb(B_PCIN) | sb(B_READ) | sb(B_MDRIN), '0,
                 1'b0, rbit(), 1'b0, 1'b0, '0);
        push_err_tail(2'b10);
        execute();
    endtask

    task automatic test_illegal();
        gen_instr(make_instr(5'b11111), 0, 1'b1, 1'b1);
        gen_instr(make_instr(5'd0), 2, 1'b1, 1'b1);
        execute();
    endtask

    task automatic test_abort();
        abort_at = 5;
        gen_instr(make_instr(5'd6), 0, 1'b1, 1'b1);
        abort_at = -1;
        aborted  = 1'b0;
        for (int i = 0; i < 3; i++)
            push("AFTER_ABORT", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0, rbit(), 1'b0, '0);
        execute();
    endtask

    task automatic test_random();
        bit idle;
        bit cont;
        int waits;
        idle = 1'b1;
        for (int n = 0; n < 40; n++) begin
            waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
            cont  = (n == 39) ? 1'b0 : bit'(rbit());
            gen_instr(rand_legal(), waits, idle, cont);
            idle = !cont;
            execute();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_shra();
        test_back_to_back();
        test_mem_wait();
        test_wait_limit_edge();
        test_timeout();
        test_illegal();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
